// File: rtl/wave_capture_ctrl.sv
// ============================================================================
// Module   : wave_capture_ctrl
// Brief    : Triggered, decimated, double-buffered waveform capture sequencer.
//            Optional WAVE_CAP_AUTO_EN adds a forced capture after AUTO_TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_capture_ctrl #(
    parameter int COLS       = 96,
    parameter int DW         = 12,
    parameter int DEF_DECIM  = 0,
    parameter int HOLD_TICKS = 2000
`ifdef WAVE_CAP_AUTO_EN
    ,
    parameter int AUTO_TIMEOUT = 4096
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_tick,
    input  logic [DW-1:0] mic_in,
    input  logic          pause_switch,
    input  logic          sp_up,
    input  logic          sp_down,
    input  logic [DW-1:0] trig_level,
    input  logic [6:0]    rd_x,
    output logic [DW-1:0] rd_data,
    output logic          frame_valid,
    output logic          frame_done,
    output logic [2:0]    decim_sel,
    output logic [1:0]    state
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAP  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_front;
    logic          r_fvalid;
    logic          r_fdone;
    logic [2:0]    r_decim;
    logic [6:0]    r_dcnt;
    logic [6:0]    r_widx;
    logic [HW-1:0] r_hold;
    logic [DW-1:0] r_prev;
    logic          r_pvalid;
    logic [DW-1:0] r_rd;

    logic [DW-1:0] r_mem0 [0:COLS-1];
    logic [DW-1:0] r_mem1 [0:COLS-1];

    logic          w_up;
    logic          w_dn;
    logic          w_dchg;
    logic          w_run;
    logic [6:0]    w_dmax;
    logic          w_dstb;
    logic          w_trig;
    logic          w_force;
    logic          w_start;
    logic          w_last;
    logic          w_wr_en;
    logic [6:0]    w_wr_addr;
    logic          w_rd_ok;
    logic [6:0]    w_rd_addr;

    // Speed changes saturate; simultaneous up+down is treated as no request.
    assign w_up   = sp_up && !sp_down && (r_decim != 3'd0);
    assign w_dn   = sp_down && !sp_up && (r_decim != 3'd7);
    assign w_dchg = w_up || w_dn;
    assign w_run  = sample_tick && !pause_switch;
    assign w_dmax = 7'((8'd1 << r_decim) - 8'd1);
    assign w_dstb = w_run && !w_dchg && (r_dcnt == w_dmax);

    assign w_trig = r_pvalid && (r_prev < trig_level) && (mic_in >= trig_level);

`ifdef WAVE_CAP_AUTO_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;
    assign w_force = (r_tcnt == TW'(AUTO_TIMEOUT - 1));
`else
    assign w_force = 1'b0;
`endif

    assign w_start   = (r_state == S_WAIT) && w_dstb && (w_trig || w_force);
    assign w_last    = (r_widx == 7'(COLS - 1));
    assign w_wr_en   = w_start || ((r_state == S_CAP) && w_dstb);
    assign w_wr_addr = (r_state == S_CAP) ? r_widx : 7'd0;
    assign w_rd_ok   = r_fvalid && (rd_x < 7'(COLS));
    assign w_rd_addr = (rd_x < 7'(COLS)) ? rd_x : 7'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_decim <= 3'(DEF_DECIM);
            r_dcnt  <= 7'd0;
        end else begin
            if (w_up) begin
                r_decim <= r_decim - 3'd1;
            end else if (w_dn) begin
                r_decim <= r_decim + 3'd1;
            end
            if (w_dchg) begin
                r_dcnt <= 7'd0;
            end else if (w_run) begin
                r_dcnt <= (r_dcnt == w_dmax) ? 7'd0 : r_dcnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_front  <= 1'b0;
            r_fvalid <= 1'b0;
            r_fdone  <= 1'b0;
            r_widx   <= 7'd0;
            r_hold   <= '0;
            r_prev   <= '0;
            r_pvalid <= 1'b0;
`ifdef WAVE_CAP_AUTO_EN
            r_tcnt   <= '0;
`endif
        end else begin
            r_fdone <= 1'b0;
            if (!pause_switch) begin
                case (r_state)
                    S_IDLE: begin
                        r_state  <= S_WAIT;
                        r_pvalid <= 1'b0;
`ifdef WAVE_CAP_AUTO_EN
                        r_tcnt   <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (w_dstb) begin
                            r_prev   <= mic_in;
                            r_pvalid <= 1'b1;
`ifdef WAVE_CAP_AUTO_EN
                            r_tcnt   <= r_tcnt + 1'b1;
`endif
                            if (w_start) begin
                                r_widx  <= 7'd1;
                                r_state <= S_CAP;
                            end
                        end
                    end
                    S_CAP: begin
                        if (w_dstb) begin
                            if (w_last) begin
                                r_front  <= ~r_front;
                                r_fdone  <= 1'b1;
                                r_fvalid <= 1'b1;
                                r_hold   <= '0;
                                r_state  <= S_HOLD;
                            end else begin
                                r_widx <= r_widx + 7'd1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (w_run) begin
                            if (r_hold == HW'(HOLD_TICKS - 1)) begin
                                r_state  <= S_WAIT;
                                r_pvalid <= 1'b0;
`ifdef WAVE_CAP_AUTO_EN
                                r_tcnt   <= '0;
`endif
                            end else begin
                                r_hold <= r_hold + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Writes always land in the bank that is not currently being displayed.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (r_front) begin
                r_mem0[w_wr_addr] <= mic_in;
            end else begin
                r_mem1[w_wr_addr] <= mic_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= '0;
        end else if (w_rd_ok) begin
            r_rd <= r_front ? r_mem1[w_rd_addr] : r_mem0[w_rd_addr];
        end else begin
            r_rd <= '0;
        end
    end

    assign rd_data     = r_rd;
    assign frame_valid = r_fvalid;
    assign frame_done  = r_fdone;
    assign decim_sel   = r_decim;
    assign state       = r_state;

endmodule

`default_nettype wire
